bcd_scan_counter: RTL and testbench

Four-digit BCD event/seconds counter with a time-multiplexed digit scanner, sitting directly upstream of the 7-segment decoder. It counts 0000–9999 on a prescaled tick. Each scan slot presents one BCD digit on a 4-bit bus to the decoder's `x` input and drives the matching active-low digit enable. All outputs are registered.

---
 rtl/bcd_scan_pkg.sv | 23 ++
 rtl/bcd_scan_counter_if.sv | 32 +++
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_scan_counter.sv | 166 ++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - shared types and constants for the BCD scan counter
//
// Purpose: digit/select types, digit count and the scan-state encoding used
// by bcd_digit, bcd_scan_counter_if and bcd_scan_counter.
// Ports: none (package).
package bcd_scan_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] sel_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // One state per displayed digit slot.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bcd_scan_counter_if.sv
// rtl/bcd_scan_counter_if.sv - control/display bundle of the BCD scan counter
//
// Purpose: groups the run/clear controls and the registered display outputs.
// Ports (signals):
//   run    - prescaler enable
//   clr    - synchronous clear of prescaler and count
//   digit  - BCD value of the slot being scanned (to decoder x input)
//   an_n   - active-low digit enables, bit i = digit i
//   count  - packed BCD count, [3:0] = units
//   wrap   - one-cycle pulse on 9999 -> 0000
// Modports: master (controller side), slave (counter side).
interface bcd_scan_counter_if;
  import bcd_scan_pkg::*;

  logic        run;
  logic        clr;
  bcd_t        digit;
  logic [3:0]  an_n;
  logic [15:0] count;
  logic        wrap;

  modport master (
    output run, clr,
    input  digit, an_n, count, wrap
  );

  modport slave (
    input  run, clr,
    output digit, an_n, count, wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade of the BCD counter
//
// Purpose: single 0..9 decade with clear and increment, carry-out combinational.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear (priority over inc)
//   inc        - increment this decade this cycle
//   q          - current decade value
//   co         - carry into next decade: inc && q == 9
module bcd_digit
  import bcd_scan_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic co
);

  assign co = inc && (q == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? bcd_t'(0) : q + bcd_t'(1);
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - four-digit BCD counter with multiplexed digit scanner
//
// Purpose: prescaled 0000..9999 BCD counter feeding a time-multiplexed
// 7-segment digit scanner. All outputs registered.
// Optional feature: define BCD_SCAN_LEAD_ZERO_BLANK_EN for leading-zero blanking.
// Parameters:
//   TICK_DIV - clock cycles per count increment (>= 1)
//   SCAN_DIV - clock cycles per scan slot (>= 1)
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - bcd_scan_counter_if.slave (run, clr, digit, an_n, count, wrap)
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_scan_counter_if.slave   bus
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // ---------------- prescaler ----------------
  logic [PRE_W-1:0] pre;
  logic             tick;

  // With TICK_DIV=1, pre is stuck at 0 == PRE_LAST so tick follows run.
  assign tick = bus.run && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (bus.clr || tick) begin
      pre <= '0;
    end else if (bus.run) begin
      pre <= pre + PRE_W'(1);
    end
  end

  // ---------------- BCD decades ----------------
  bcd_t                  q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] inc;
  logic [NUM_DIGITS-1:0] co;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    // co already contains the lower inc, so chaining co is tick && AND of lower carries.
    if (g == 0) begin : g_first
      assign inc[g] = tick;
    end else begin : g_rest
      assign inc[g] = co[g-1];
    end

    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr),
      .inc   (inc[g]),
      .q     (q[g]),
      .co    (co[g])
    );
  end

  assign bus.count = {q[3], q[2], q[1], q[0]};

  // ---------------- wrap pulse ----------------
  logic wrap_q;

  // co[3] means tick with all decades at 9; a coincident clr suppresses the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= co[NUM_DIGITS-1] && !bus.clr;
    end
  end

  assign bus.wrap = wrap_q;

  // ---------------- scanner ----------------
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_last;
  scan_state_t       state_q;
  scan_state_t       state_d;
  sel_t              sel;

  assign scan_last = (scan_cnt == SCAN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (scan_last) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = sel_t'(state_q);
    if (scan_last) begin
      case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        S3:      state_d = S0;
        default: state_d = S0;
      endcase
    end
  end

  // ---------------- blanking ----------------
  logic blank;

`ifdef BCD_SCAN_LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_above;  // bit i: digits i..3 are all zero

  always_comb begin
    zero_above    = '0;
    zero_above[3] = (q[3] == 4'd0);
    zero_above[2] = zero_above[3] && (q[2] == 4'd0);
    zero_above[1] = zero_above[2] && (q[1] == 4'd0);
    zero_above[0] = zero_above[1] && (q[0] == 4'd0);
  end

  // Units digit is never blanked.
  assign blank = (sel != 2'd0) && zero_above[sel];
`else
  assign blank = 1'b0;
`endif

  // ---------------- output register ----------------
  bcd_t       digit_q;
  logic [3:0] an_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      an_q    <= 4'b1110;
    end else if (blank) begin
      digit_q <= '0;
      an_q    <= 4'b1111;
    end else begin
      digit_q <= q[sel];
      an_q    <= ~(4'b0001 << sel);
    end
  end

  assign bus.digit = digit_q;
  assign bus.an_n  = an_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic clk;
  logic rst_n;

  bcd_scan_counter_if bus ();

  bcd_scan_counter #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: decimal count, prescale phase, cycles since reset.
  int         m_cnt;
  int         m_pre;
  int         m_cyc;
  logic [3:0] m_digit;
  logic [3:0] m_an;
  logic       m_wrap;
  int         pow10 [4] = '{1, 10, 100, 1000};

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_cyc = 0;
    m_digit = 4'h0; m_an = 4'b1110; m_wrap = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic c);
    int  s;
    bit  tk;
    s = (m_cyc / SCAN_DIV) % 4;
    m_digit = 4'((m_cnt / pow10[s]) % 10);
    m_an    = ~(4'b0001 << s);
`ifdef BCD_SCAN_LEAD_ZERO_BLANK_EN
    if (s > 0 && m_cnt < pow10[s]) begin
      m_digit = 4'h0;
      m_an    = 4'b1111;
    end
`endif
    tk = r && (m_pre == TICK_DIV - 1);
    if (c) begin
      m_pre = 0; m_cnt = 0; m_wrap = 1'b0;
    end else begin
      if (r) m_pre = (m_pre + 1) % TICK_DIV;
      m_wrap = tk && (m_cnt == 9999);
      if (tk) m_cnt = (m_cnt + 1) % 10000;
    end
    m_cyc++;
  endtask

  int wrap_hits;

  task automatic step(input logic r, input logic c);
    logic ok;
    bus.run = r;
    bus.clr = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (bus.count[4*i +: 4] > 4'd9) ok = 1'b0;
    if (bus.digit > 4'd9) ok = 1'b0;
    check("bcd_valid", 32'(ok), 32'd1);
    check("count", 32'(bus.count), 32'(to_bcd(m_cnt)));
    check("digit", 32'(bus.digit), 32'(m_digit));
    check("an_n",  32'(bus.an_n),  32'(m_an));
    check("wrap",  32'(bus.wrap),  32'(m_wrap));
    if (bus.wrap) wrap_hits++;
  endtask

  typedef struct {
    logic        run;
    logic        clr;
    int          cycles;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [3:0] an_seq [8];
    int         n_blank;
    int         n_slot0;

    vecs[0] = '{1'b1, 1'b0, 40, 16'h0010};
    vecs[1] = '{1'b0, 1'b0, 20, 16'h0010};
    vecs[2] = '{1'b1, 1'b0, 36, 16'h0019};
    vecs[3] = '{1'b1, 1'b1, 3,  16'h0000};
    vecs[4] = '{1'b1, 1'b0, 37, 16'h0009};

`ifdef BCD_SCAN_LEAD_ZERO_BLANK_EN
    an_seq = '{4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
`else
    an_seq = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
`endif

    rst_n   = 1'b0;
    bus.run = 1'b0;
    bus.clr = 1'b0;
    wrap_hits = 0;
    model_reset();
    #12;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_digit", 32'(bus.digit), 32'h0);
    check("rst_an_n",  32'(bus.an_n),  32'he);
    check("rst_wrap",  32'(bus.wrap),  32'h0);
    rst_n = 1'b1;

    // Scan sequence after reset, 2 cycles per slot.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      check("scan_seq_an_n", 32'(bus.an_n), 32'(an_seq[i]));
    end

    // Run a little, then hit reset asynchronously mid-cycle.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count), 32'h0);
    check("async_rst_digit", 32'(bus.digit), 32'h0);
    check("async_rst_an_n",  32'(bus.an_n),  32'he);
    check("async_rst_wrap",  32'(bus.wrap),  32'h0);
    model_reset();
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_an_n", 32'(bus.an_n), 32'he);
    rst_n = 1'b1;

    // Table-driven phases.
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].run, vecs[v].clr);
      check("vec_count", 32'(bus.count), 32'(vecs[v].exp_count));
    end

    // clr coincident with the tick at 0009: no carry into tens, no wrap.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("clr_tick_count", 32'(bus.count), 32'h0);
    check("clr_tick_wrap",  32'(bus.wrap),  32'h0);

    // Scan content at 1234.
    for (int i = 0; i < 1234 * TICK_DIV; i++) step(1'b1, 1'b0);
    check("count_1234", 32'(bus.count), 32'h1234);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      case (bus.an_n)
        4'b1110: check("scan_1234_d0", 32'(bus.digit), 32'd4);
        4'b1101: check("scan_1234_d1", 32'(bus.digit), 32'd3);
        4'b1011: check("scan_1234_d2", 32'(bus.digit), 32'd2);
        4'b0111: check("scan_1234_d3", 32'(bus.digit), 32'd1);
        default: check("scan_1234_onehot", 32'(bus.an_n), 32'he);
      endcase
    end

    // Rollover.
    step(1'b0, 1'b1);
    for (int i = 0; i < 9999 * TICK_DIV; i++) step(1'b1, 1'b0);
    check("count_9999", 32'(bus.count), 32'h9999);
    wrap_hits = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("rollover_count", 32'(bus.count), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("wrap_pulses", 32'(wrap_hits), 32'd1);

`ifdef BCD_SCAN_LEAD_ZERO_BLANK_EN
    step(1'b0, 1'b1);
    for (int i = 0; i < 42 * TICK_DIV; i++) step(1'b1, 1'b0);
    check("count_0042", 32'(bus.count), 32'h0042);
    n_blank = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      if (bus.an_n == 4'b1111) begin
        n_blank++;
        check("blank_digit", 32'(bus.digit), 32'd0);
      end
    end
    check("blank_slots_0042", 32'(n_blank), 32'd4);
    step(1'b0, 1'b1);
    n_slot0 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      if (bus.an_n == 4'b1110) begin
        n_slot0++;
        check("zero_slot0_digit", 32'(bus.digit), 32'd0);
      end
    end
    check("zero_slot0_count", 32'(n_slot0), 32'd2);
`endif

    // Randomized run/clr against the model.
    for (int i = 0; i < 3000; i++) begin
      step(logic'(($urandom % 4) != 0), logic'(($urandom % 64) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
